// File: rtl/fft_stream_ctrl.sv
// AXI-Stream wrapper around the Xilinx FFT core. It handles configuration, framed sample
// packing with tlast, result unpacking, and frame and error counters.
module fft_stream_ctrl #(
  parameter int DATA_W    = 14,
  parameter int LANE_W    = 16,
  parameter int OUT_W     = 14,
  parameter int NFFT_LOG2 = 9,
  parameter bit FWD_INIT  = 1'b1
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_re,
  input  logic [DATA_W-1:0]      in_im,
  output logic                   in_ready,
  input  logic                   fwd_inv,
  input  logic                   cfg_req,
  output logic [15:0]            s_axis_config_tdata,
  output logic                   s_axis_config_tvalid,
  input  logic                   s_axis_config_tready,
  output logic [2*LANE_W-1:0]    s_axis_data_tdata,
  output logic                   s_axis_data_tvalid,
  output logic                   s_axis_data_tlast,
  input  logic                   s_axis_data_tready,
  input  logic [2*LANE_W-1:0]    m_axis_data_tdata,
  input  logic [23:0]            m_axis_data_tuser,
  input  logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tlast,
  output logic                   m_axis_data_tready,
  input  logic                   event_tlast_unexpected,
  input  logic                   event_tlast_missing,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [OUT_W-1:0]       out_re,
  output logic [OUT_W-1:0]       out_im,
  output logic [NFFT_LOG2-1:0]   out_index,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             err_unexp,
  output logic [7:0]             err_miss,
  output logic                   busy
);

  typedef enum logic {S_CFG, S_RUN} state_t;

  localparam logic [4:0]           NLOG    = 5'(NFFT_LOG2);
  localparam logic [NFFT_LOG2-1:0] CNT_MAX = '1;

  state_t               state_q;
  logic                 dir_q;
  logic                 pend_q;
  logic                 cfg_vld_q;
  logic                 mrdy_q;
  logic [NFFT_LOG2-1:0] cnt_q;
  logic                 out_valid_q, out_last_q;
  logic [OUT_W-1:0]     out_re_q, out_im_q;
  logic [NFFT_LOG2-1:0] out_index_q;
  logic [15:0]          frame_q;
  logic [7:0]           err_unexp_q, err_miss_q;

  logic                 run, hold, beat, m_acc;
  logic [LANE_W-1:0]    re_x, im_x;
  logic                 unused_bits;

  // A pending reconfiguration only blocks input at a frame boundary, so frames are never split.
  assign run  = (state_q == S_RUN) & ~rst;
  assign hold = pend_q & (cnt_q == '0);
  assign re_x = LANE_W'($signed(in_re));
  assign im_x = LANE_W'($signed(in_im));

  assign in_ready             = run & s_axis_data_tready & ~hold;
  assign beat                 = in_valid & in_ready;
  assign s_axis_data_tvalid   = beat;
  assign s_axis_data_tlast    = beat & (cnt_q == CNT_MAX);
  assign s_axis_data_tdata    = beat ? {im_x, re_x} : '0;
  assign s_axis_config_tvalid = cfg_vld_q;
  assign s_axis_config_tdata  = cfg_vld_q ? {7'd0, dir_q, 3'd0, NLOG} : '0;
  assign busy                 = ~rst & ((state_q != S_RUN) | (cnt_q != '0));

  assign m_acc              = m_axis_data_tvalid & mrdy_q;
  assign m_axis_data_tready = mrdy_q;
  assign out_valid          = out_valid_q;
  assign out_last           = out_last_q;
  assign out_re             = out_re_q;
  assign out_im             = out_im_q;
  assign out_index          = out_index_q;
  assign frame_cnt          = frame_q;
  assign err_unexp          = err_unexp_q;
  assign err_miss           = err_miss_q;
  assign unused_bits        = ^{m_axis_data_tdata, m_axis_data_tuser};

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= S_CFG;
      dir_q       <= FWD_INIT;
      pend_q      <= 1'b0;
      cfg_vld_q   <= 1'b0;
      mrdy_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_index_q <= '0;
      frame_q     <= '0;
      err_unexp_q <= '0;
      err_miss_q  <= '0;
    end else begin
      mrdy_q <= 1'b1;
      if (beat) cnt_q <= cnt_q + NFFT_LOG2'(1);

      // The first CFG cycle after reset samples the requested direction; later entries sample it on the transition.
      case (state_q)
        S_CFG: begin
          if (!cfg_vld_q) begin
            cfg_vld_q <= 1'b1;
            dir_q     <= fwd_inv;
          end else if (s_axis_config_tready) begin
            cfg_vld_q <= 1'b0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (hold) begin
            state_q   <= S_CFG;
            pend_q    <= 1'b0;
            cfg_vld_q <= 1'b1;
            dir_q     <= fwd_inv;
          end else begin
            pend_q <= pend_q | cfg_req | (fwd_inv != dir_q);
          end
        end
        default: state_q <= S_CFG;
      endcase

      out_valid_q <= m_acc;
      out_last_q  <= m_acc & m_axis_data_tlast;
      if (m_acc) begin
        out_re_q    <= m_axis_data_tdata[OUT_W-1:0];
        out_im_q    <= m_axis_data_tdata[LANE_W +: OUT_W];
        out_index_q <= m_axis_data_tuser[NFFT_LOG2-1:0];
      end
      if (m_acc & m_axis_data_tlast) frame_q <= frame_q + 16'd1;

      if (event_tlast_unexpected && err_unexp_q != 8'hFF) err_unexp_q <= err_unexp_q + 8'd1;
      if (event_tlast_missing && err_miss_q != 8'hFF) err_miss_q <= err_miss_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl with an 8-point frame, driven by random samples and results.
module tb_fft_stream_ctrl;
  localparam int DATA_W = 14;
  localparam int LANE_W = 16;
  localparam int OUT_W  = 14;
  localparam int NL     = 3;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic rst, in_valid, in_ready, fwd_inv, cfg_req;
  logic [DATA_W-1:0] in_re, in_im;
  logic [15:0] s_axis_config_tdata;
  logic s_axis_config_tvalid, s_axis_config_tready;
  logic [2*LANE_W-1:0] s_axis_data_tdata, m_axis_data_tdata;
  logic s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tready;
  logic [23:0] m_axis_data_tuser;
  logic m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tready;
  logic event_tlast_unexpected, event_tlast_missing;
  logic out_valid, out_last, busy;
  logic [OUT_W-1:0] out_re, out_im;
  logic [NL-1:0] out_index;
  logic [15:0] frame_cnt;
  logic [7:0] err_unexp, err_miss;

  fft_stream_ctrl #(.DATA_W(DATA_W), .LANE_W(LANE_W), .OUT_W(OUT_W), .NFFT_LOG2(NL), .FWD_INIT(1'b1)) dut (
    .sclk(sclk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im), .in_ready(in_ready),
    .fwd_inv(fwd_inv), .cfg_req(cfg_req),
    .s_axis_config_tdata(s_axis_config_tdata), .s_axis_config_tvalid(s_axis_config_tvalid),
    .s_axis_config_tready(s_axis_config_tready),
    .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tuser(m_axis_data_tuser),
    .m_axis_data_tvalid(m_axis_data_tvalid), .m_axis_data_tlast(m_axis_data_tlast),
    .m_axis_data_tready(m_axis_data_tready),
    .event_tlast_unexpected(event_tlast_unexpected), .event_tlast_missing(event_tlast_missing),
    .out_valid(out_valid), .out_last(out_last), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .frame_cnt(frame_cnt), .err_unexp(err_unexp), .err_miss(err_miss),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cur_re, cur_im;
  int exp_frames = 0;

  function automatic logic [15:0] lane(input int v);
    return 16'((v + 65536) % 65536);
  endfunction

  function automatic logic [15:0] cfg_word(input logic d);
    return 16'(int'(d) * 256 + NL);
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic new_sample();
    cur_re = int'($urandom_range(16383)) - 8192;
    cur_im = int'($urandom_range(16383)) - 8192;
    in_re  = DATA_W'(cur_re);
    in_im  = DATA_W'(cur_im);
  endtask

  task automatic test_reset();
    int cyc = 0;
    rst = 1'b1; in_valid = 1'b1; fwd_inv = 1'b1; cfg_req = 1'b0;
    s_axis_config_tready = 1'b1; s_axis_data_tready = 1'b1;
    m_axis_data_tvalid = 1'b1; m_axis_data_tlast = 1'b1;
    m_axis_data_tdata = '1; m_axis_data_tuser = '1;
    event_tlast_unexpected = 1'b1; event_tlast_missing = 1'b1;
    new_sample();
    tick(); tick(); #1;
    n_cmp++;
    if ({in_ready, s_axis_data_tvalid, s_axis_data_tlast, s_axis_config_tvalid, m_axis_data_tready,
         out_valid, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000000", {in_ready, s_axis_data_tvalid, s_axis_data_tlast,
               s_axis_config_tvalid, m_axis_data_tready, out_valid, busy});
    end
    n_cmp++;
    if ({frame_cnt, err_unexp, err_miss} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_counters: got %h want 0", {frame_cnt, err_unexp, err_miss});
    end
    rst = 1'b0; m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
    event_tlast_unexpected = 1'b0; event_tlast_missing = 1'b0;
    while (s_axis_config_tvalid !== 1'b1 && cyc < 6) begin tick(); cyc++; end
    n_cmp++;
    if (s_axis_config_tvalid !== 1'b1 || s_axis_config_tdata !== cfg_word(1'b1) || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_config: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", s_axis_config_tvalid,
               s_axis_config_tdata, in_ready, cfg_word(1'b1));
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, s_axis_config_tvalid, m_axis_data_tready, busy} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_run: got %b want 1010", {in_ready, s_axis_config_tvalid, m_axis_data_tready, busy});
    end
  endtask

  task automatic test_stream();
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      new_sample();
      if (k == 5) begin cur_re = -1; in_re = DATA_W'(cur_re); end
      #1;
      n_cmp++;
      if (s_axis_data_tvalid !== 1'b1 || s_axis_data_tdata !== {lane(cur_im), lane(cur_re)} ||
          s_axis_data_tlast !== (k % 8 == 7)) begin
        n_err++;
        $display("FAIL stream_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, s_axis_data_tvalid,
                 s_axis_data_tdata, s_axis_data_tlast, {lane(cur_im), lane(cur_re)}, (k % 8 == 7));
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reconfig(input bit use_req);
    int sent = 0, cyc = 0, cfgs = 0;
    bit took, pulsed = 0;
    logic new_dir;
    new_dir = use_req ? fwd_inv : ~fwd_inv;
    new_sample(); in_valid = 1'b1;
    while (sent < 16 && cyc < 100) begin
      if (sent == 3 && !use_req) fwd_inv = new_dir;
      cfg_req = use_req && sent == 3 && !pulsed;
      if (cfg_req) pulsed = 1;
      #1;
      if (s_axis_config_tvalid === 1'b1) begin
        n_cmp++;
        if (s_axis_config_tdata !== cfg_word(new_dir) || sent != 8) begin
          n_err++;
          $display("FAIL reconfig%0d_cfg: got d=%h at beat %0d want d=%h at beat 8", use_req,
                   s_axis_config_tdata, sent, cfg_word(new_dir));
        end
        cfgs++;
      end
      if (sent >= 3 && sent < 8) begin
        n_cmp++;
        if (s_axis_data_tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL reconfig%0d_tail: got tvalid=%b at beat %0d want 1", use_req, s_axis_data_tvalid, sent);
        end
      end
      if (s_axis_data_tvalid === 1'b1) begin
        n_cmp++;
        if (s_axis_data_tdata !== {lane(cur_im), lane(cur_re)} || s_axis_data_tlast !== (sent % 8 == 7) ||
            (sent >= 8 && cfgs != 1)) begin
          n_err++;
          $display("FAIL reconfig%0d_beat%0d: got d=%h l=%b cfgs=%0d want d=%h l=%b", use_req, sent,
                   s_axis_data_tdata, s_axis_data_tlast, cfgs, {lane(cur_im), lane(cur_re)}, (sent % 8 == 7));
        end
      end
      took = s_axis_data_tvalid;
      tick(); cyc++;
      if (took) begin sent++; new_sample(); end
    end
    cfg_req = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (sent != 16 || cfgs != 1) begin
      n_err++;
      $display("FAIL reconfig%0d_count: got beats=%0d cfgs=%0d want 16/1", use_req, sent, cfgs);
    end
  endtask

  task automatic test_stall();
    int sent = 0, cyc = 0;
    bit took;
    new_sample(); in_valid = 1'b1;
    while (sent < 16 && cyc < 100) begin
      s_axis_data_tready = !(cyc >= 4 && cyc < 9);
      #1;
      if (!s_axis_data_tready) begin
        n_cmp++;
        if ({in_ready, s_axis_data_tvalid, busy} !== 3'b001) begin
          n_err++;
          $display("FAIL stall_hold: got %b want 001", {in_ready, s_axis_data_tvalid, busy});
        end
      end
      if (s_axis_data_tvalid === 1'b1) begin
        n_cmp++;
        if (s_axis_data_tdata !== {lane(cur_im), lane(cur_re)} || s_axis_data_tlast !== (sent % 8 == 7)) begin
          n_err++;
          $display("FAIL stall_beat%0d: got d=%h l=%b want d=%h l=%b", sent, s_axis_data_tdata,
                   s_axis_data_tlast, {lane(cur_im), lane(cur_re)}, (sent % 8 == 7));
        end
      end
      took = s_axis_data_tvalid;
      tick(); cyc++;
      if (took) begin sent++; new_sample(); end
    end
    s_axis_data_tready = 1'b1; in_valid = 1'b0;
    n_cmp++;
    if (sent != 16 || cyc != 21) begin
      n_err++;
      $display("FAIL stall_count: got beats=%0d cycles=%0d want 16/21", sent, cyc);
    end
  endtask

  task automatic test_random_flow();
    int sent = 0, cyc = 0;
    bit took;
    new_sample();
    while (sent < 24 && cyc < 400) begin
      in_valid = ($urandom_range(3) != 0);
      s_axis_data_tready = ($urandom_range(3) != 0);
      #1;
      n_cmp++;
      if (s_axis_data_tvalid !== (in_valid & s_axis_data_tready) ||
          (s_axis_data_tvalid === 1'b1 && (s_axis_data_tdata !== {lane(cur_im), lane(cur_re)} ||
                                            s_axis_data_tlast !== (sent % 8 == 7)))) begin
        n_err++;
        $display("FAIL random_beat%0d: got v=%b d=%h l=%b want v=%b d=%h l=%b", sent, s_axis_data_tvalid,
                 s_axis_data_tdata, s_axis_data_tlast, in_valid & s_axis_data_tready,
                 {lane(cur_im), lane(cur_re)}, (sent % 8 == 7));
      end
      took = s_axis_data_tvalid;
      tick(); cyc++;
      if (took) begin sent++; new_sample(); end
    end
    in_valid = 1'b0; s_axis_data_tready = 1'b1;
    n_cmp++;
    if (sent != 24) begin
      n_err++;
      $display("FAIL random_count: got beats=%0d want 24", sent);
    end
  endtask

  task automatic test_result();
    logic v, l;
    logic [15:0] lr, li;
    logic [23:0] u;
    m_axis_data_tvalid = 1'b1; m_axis_data_tdata = {16'h0003, 16'h3FFF};
    m_axis_data_tuser = 24'd5; m_axis_data_tlast = 1'b0;
    tick();
    m_axis_data_tvalid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_re !== 14'h3FFF || out_im !== 14'd3 || out_index !== 3'd5 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL result_fixed: got v=%b re=%h im=%h idx=%0d l=%b want 1 3fff 0003 5 0",
               out_valid, out_re, out_im, out_index, out_last);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL result_idle: got out_valid=%b want 0", out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(1) == 1); l = ($urandom_range(4) == 0);
      lr = 16'($urandom); li = 16'($urandom); u = 24'($urandom);
      m_axis_data_tvalid = v; m_axis_data_tlast = l; m_axis_data_tdata = {li, lr}; m_axis_data_tuser = u;
      tick();
      if (v && l) exp_frames++;
      n_cmp++;
      if (out_valid !== v || frame_cnt !== 16'(exp_frames) ||
          (v && (out_re !== 14'(lr % 16384) || out_im !== 14'(li % 16384) ||
                 out_index !== 3'(u % 8) || out_last !== l))) begin
        n_err++;
        $display("FAIL result_beat%0d: got v=%b re=%h im=%h idx=%0d l=%b fc=%0d want v=%b re=%h im=%h idx=%0d l=%b fc=%0d",
                 i, out_valid, out_re, out_im, out_index, out_last, frame_cnt,
                 v, 14'(lr % 16384), 14'(li % 16384), u % 8, l, exp_frames);
      end
    end
    m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int cyc = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin new_sample(); tick(); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, s_axis_data_tvalid, s_axis_data_tlast} !== 3'b000) begin
      n_err++;
      $display("FAIL midrst_drop: got %b want 000", {in_ready, s_axis_data_tvalid, s_axis_data_tlast});
    end
    tick();
    rst = 1'b0;
    while (s_axis_config_tvalid !== 1'b1 && cyc < 6) begin tick(); cyc++; end
    n_cmp++;
    if (s_axis_config_tvalid !== 1'b1 || s_axis_config_tdata !== cfg_word(fwd_inv)) begin
      n_err++;
      $display("FAIL midrst_config: got v=%b d=%h want v=1 d=%h", s_axis_config_tvalid,
               s_axis_config_tdata, cfg_word(fwd_inv));
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      new_sample();
      #1;
      n_cmp++;
      if (s_axis_data_tvalid !== 1'b1 || s_axis_data_tdata !== {lane(cur_im), lane(cur_re)} ||
          s_axis_data_tlast !== (k == 7)) begin
        n_err++;
        $display("FAIL midrst_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, s_axis_data_tvalid,
                 s_axis_data_tdata, s_axis_data_tlast, {lane(cur_im), lane(cur_re)}, (k == 7));
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_errors();
    for (int i = 0; i < 300; i++) begin
      event_tlast_missing = 1'b1;
      event_tlast_unexpected = (i < 37);
      tick();
      if (i == 253) begin
        n_cmp++;
        if (err_miss !== 8'd254) begin
          n_err++;
          $display("FAIL err_miss_254: got %0d want 254", err_miss);
        end
      end
    end
    event_tlast_missing = 1'b0; event_tlast_unexpected = 1'b0;
    tick();
    n_cmp++;
    if (err_miss !== 8'd255 || err_unexp !== 8'd37) begin
      n_err++;
      $display("FAIL err_sat: got miss=%0d unexp=%0d want 255/37", err_miss, err_unexp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({frame_cnt, err_unexp, err_miss} !== 32'h0) begin
      n_err++;
      $display("FAIL err_reset: got %h want 0", {frame_cnt, err_unexp, err_miss});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reconfig(1'b0);
    test_reconfig(1'b1);
    test_stall();
    test_random_flow();
    test_result();
    test_reset_midframe();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
